// File: rtl/uart_loader_pkg.sv
// Shared types and defaults for the UART program loader.
package uart_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int          DEF_CLKS_PER_BIT = 347;  // 40 MHz / 115200 baud
  localparam logic [31:0] DEF_END_WORD     = 32'h0000_0FFF;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, start-bit validation, mid-bit sampling.
module uart_rx_byte
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int          CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_e     state, state_d;
  logic          rx_s1, rx_s2;
  logic [CW-1:0] baud_cnt, baud_cnt_d;
  logic [2:0]    bit_cnt, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
    end else begin
      rx_s1    <= rx_i;
      rx_s2    <= rx_s1;
      state    <= state_d;
      baud_cnt <= baud_cnt_d;
      bit_cnt  <= bit_cnt_d;
      shift_q  <= shift_d;
    end
  end

  always_comb begin
    state_d      = state;
    baud_cnt_d   = baud_cnt + CW'(1);
    bit_cnt_d    = bit_cnt;
    shift_d      = shift_q;
    byte_valid_o = 1'b0;
    frame_err_o  = 1'b0;
    case (state)
      IDLE: begin
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!rx_s2) state_d = START;
      end
      START: begin
        // A start bit still high at mid-bit is a line glitch: drop it silently.
        if (baud_cnt == HALF) begin
          baud_cnt_d = '0;
          state_d    = rx_s2 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (baud_cnt == FULL) begin
          baud_cnt_d = '0;
          shift_d    = {rx_s2, shift_q[7:1]};
          bit_cnt_d  = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (baud_cnt == FULL) begin
          baud_cnt_d   = '0;
          state_d      = IDLE;
          byte_valid_o = rx_s2;
          frame_err_o  = !rx_s2;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_o = shift_q;

endmodule

// File: rtl/uart_prog_loader.sv
// Assembles received bytes into little-endian words and streams them into instruction memory.
module uart_prog_loader
  import uart_loader_pkg::*;
#(
  parameter int          CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int          ADDR_W       = 10,
  parameter logic [31:0] END_WORD     = DEF_END_WORD
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              rx_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              prog_done_o,
  output logic              frame_err_o
);

  logic [7:0]  rx_byte;
  logic        rx_valid, rx_ferr;
  logic [1:0]  byte_cnt;
  logic [23:0] word_q;
  logic [31:0] full_word;
  logic        addr_last;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .wb_clk_i     (wb_clk_i),
    .wb_rst_i     (wb_rst_i),
    .rx_i         (rx_i),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_err_o  (rx_ferr)
  );

  assign full_word = {rx_byte, word_q};
  assign addr_last = (imem_addr_o == {ADDR_W{1'b1}});

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      imem_we_o    <= 1'b0;
      imem_addr_o  <= '0;
      imem_wdata_o <= '0;
      prog_done_o  <= 1'b0;
      frame_err_o  <= 1'b0;
      byte_cnt     <= '0;
      word_q       <= '0;
    end else begin
      imem_we_o   <= 1'b0;
      frame_err_o <= rx_ff_err_q(rx_ferr);
      // Address advances after the write cycle and sticks at the top of memory.
      if (imem_we_o && !addr_last) imem_addr_o <= imem_addr_o + ADDR_W'(1);
      if (rx_ferr) begin
        byte_cnt <= '0;
      end else if (rx_valid) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0: word_q[7:0]   <= rx_byte;
          2'd1: word_q[15:8]  <= rx_byte;
          2'd2: word_q[23:16] <= rx_byte;
          default: begin
            if (!prog_done_o) begin
              if (full_word == END_WORD) begin
                prog_done_o <= 1'b1;
              end else begin
                imem_we_o    <= 1'b1;
                imem_wdata_o <= full_word;
                if (addr_last) prog_done_o <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  function automatic logic rx_ff_err_q(input logic e);
    return e;
  endfunction

endmodule

// File: doc/uart_prog_loader.md
UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 347, wb_clk_i cycles per UART bit (40 MHz / 115200 baud); SHALL be >= 4.
REQ-002 Parameter ADDR_W, default 10, instruction-memory word-address width.
REQ-003 Parameter END_WORD, default 32'h0000_0FFF, terminating word that ends a load.
REQ-004 wb_clk_i  input  1  sole clock.
REQ-005 wb_rst_i  input  1  reset; synchronous, active-high.
REQ-006 rx_i  input  1  asynchronous UART serial in (from mprj_io[5]); idle high; 8N1 format.
REQ-007 imem_we_o  output  1  one-cycle instruction-memory write strobe.
REQ-008 imem_addr_o  output  ADDR_W  word address of the current write.
REQ-009 imem_wdata_o  output  32  write data; valid only while imem_we_o is high.
REQ-010 prog_done_o  output  1  sticky load-complete flag (drives mprj_io[37]).
REQ-011 frame_err_o  output  1  one-cycle pulse on a bad stop bit.

Function
REQ-012 rx_i SHALL pass through a 2-flop synchronizer, both flops resetting to 1; all logic uses the synchronized value.
REQ-013 RX FSM states SHALL be IDLE, START, DATA, STOP.
REQ-014 IDLE->START on synchronized rx low.
REQ-015 START: wait CLKS_PER_BIT/2 cycles, then sample; low->DATA, high->IDLE (glitch rejected, no byte, no error).
REQ-016 DATA: sample 8 bits, LSB first, one every CLKS_PER_BIT cycles, then ->STOP.
REQ-017 STOP: sample after CLKS_PER_BIT cycles; high = byte valid; low = frame_err_o pulse, byte discarded; either case ->IDLE.
REQ-018 Valid bytes SHALL be packed little-endian: byte 0 into [7:0] through byte 3 into [31:24]; a 2-bit byte counter tracks position.
REQ-019 A frame error SHALL clear the byte counter; the partial word is discarded.
REQ-020 On the 4th valid byte of a non-END_WORD word, imem_we_o SHALL be high for exactly one cycle, the cycle after the stop-bit sample, with imem_addr_o = current address; the address then increments by 1.
REQ-021 A completed word equal to END_WORD SHALL NOT be written and SHALL set prog_done_o the cycle after the stop-bit sample.
REQ-022 A write to address 2^ADDR_W-1 SHALL set prog_done_o in the same cycle as imem_we_o (memory full); the address does not wrap.
REQ-023 While prog_done_o is high, the receiver keeps running but no write occurs; prog_done_o is cleared only by reset.
REQ-024 imem_addr_o SHALL hold its value between writes.

Reset
REQ-025 On wb_rst_i high at a clock edge: FSM=IDLE, counters=0, imem_addr_o=0, imem_wdata_o=0, imem_we_o=0, prog_done_o=0, frame_err_o=0, synchronizer=1.
REQ-026 Reset mid-byte or mid-word SHALL discard all partial data; no write is issued in the reset cycle or after it.

Structure
REQ-027 Package uart_loader_pkg SHALL hold the RX state enum, the default CLKS_PER_BIT, and the default END_WORD.
REQ-028 Sub-module uart_rx_byte SHALL contain the synchronizer, RX FSM, and bit/baud counters; outputs byte_o[7:0], byte_valid_o (pulse), frame_err_o (pulse).
REQ-029 The top level SHALL contain word assembly, address counter, and done logic only.

Verification
REQ-030 Bytes 05,00,00,00 -> one imem_we_o pulse, addr 0, data 32'h0000_0005; prog_done_o stays 0.
REQ-031 Word 32'h1234_5678, word 32'hDEAD_BEEF, then END_WORD -> writes at addr 0 and addr 1 only; prog_done_o=1 one cycle after the last stop bit; no third write.
REQ-032 rx_i low for CLKS_PER_BIT/4 cycles -> no byte, no frame_err_o, FSM back in IDLE.
REQ-033 Bytes AA,BB, then a byte with stop bit 0 -> frame_err_o pulse; following bytes 01,02,03,04 -> write 32'h0403_0201 at addr 0.
REQ-034 wb_rst_i asserted during DATA of the 3rd byte -> all outputs reset; next full word is written at addr 0.
REQ-035 ADDR_W=2, four non-END words -> writes at addr 0..3; prog_done_o set with the addr-3 write; a 5th word produces no write.
